// File: rtl/seq_detector_param_if.sv
// Bus bundle for the programmable serial pattern detector.
// The master side drives the stream and configuration; the slave side
// (the detector) returns the match flag, counter and active length.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               en;
    logic               x;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap_en;
    logic               moore_mode;
    logic               cnt_clr;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic [LEN_W-1:0]   cfg_len;

    modport master (
        output en, x, cfg_load, pattern, pat_len, overlap_en, moore_mode, cnt_clr,
        input  z, match_cnt, cfg_len
    );

    modport slave (
        input  en, x, cfg_load, pattern, pat_len, overlap_en, moore_mode, cnt_clr,
        output z, match_cnt, cfg_len
    );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector.
// Keeps a shift history of en-qualified bits, compares the newest cfg_len
// bits (including the bit on x this cycle) with the programmed pattern,
// and reports matches either combinationally (Mealy) or one cycle later
// (Moore). A saturating counter tallies every match.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);

    logic [MAX_LEN-1:0] pat_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               overlap_reg;
    logic               moore_reg;
    logic [MAX_LEN-1:0] hist_reg;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   vcnt_reg;
    logic [LEN_W-1:0]   vcnt_next;
    logic               zq_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [LEN_W-1:0]   len_clamped;
    logic [MAX_LEN:0]   window;
    logic [MAX_LEN:0]   pat_ext;
    logic [MAX_LEN:0]   mask;
    logic               vcnt_ok;
    logic               pat_eq;
    logic               match;

    // Oversized lengths are clamped so the window never exceeds the history.
    assign len_clamped = (bus.pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.pat_len;

    // Window = stored history with the live bit appended as the newest bit.
    assign window  = {hist_reg, bus.x};
    assign pat_ext = {1'b0, pat_reg};

    // Only the low len_reg bits of the window take part in the compare.
    // The top bit is never selected because len_reg never exceeds MAX_LEN.
    generate
        for (genvar gi = 0; gi <= MAX_LEN; gi++) begin : g_mask
            assign mask[gi] = ({1'b0, len_reg} > (LEN_W+1)'(gi));
        end
    endgenerate

    // vcnt + 1 >= len avoids the underflow of len - 1 when len is zero.
    assign vcnt_ok = (({1'b0, vcnt_reg} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_reg});
    assign pat_eq  = (((window ^ pat_ext) & mask) == '0);
    assign match   = bus.en & ~bus.cfg_load & (len_reg != '0) & vcnt_ok & pat_eq;

    // Next history: cleared by configuration or a non-overlapping match,
    // otherwise shifted on every enabled bit.
    always_comb begin
        hist_next = hist_reg;
        vcnt_next = vcnt_reg;
        if (bus.cfg_load) begin
            hist_next = '0;
            vcnt_next = '0;
        end else if (bus.en) begin
            if (match && !overlap_reg) begin
                hist_next = '0;
                vcnt_next = '0;
            end else begin
                hist_next = window[MAX_LEN-1:0];
                vcnt_next = (vcnt_reg == LEN_W'(MAX_LEN)) ? vcnt_reg : vcnt_reg + 1'b1;
            end
        end
    end

    // Configuration registers, loaded only by a cfg_load pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_reg     <= '0;
            len_reg     <= '0;
            overlap_reg <= 1'b1;
            moore_reg   <= 1'b0;
        end else if (bus.cfg_load) begin
            pat_reg     <= bus.pattern;
            len_reg     <= len_clamped;
            overlap_reg <= bus.overlap_en;
            moore_reg   <= bus.moore_mode;
        end
    end

    // Shift history and its saturating valid-bit count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_reg <= '0;
            vcnt_reg <= '0;
        end else begin
            hist_reg <= hist_next;
            vcnt_reg <= vcnt_next;
        end
    end

    // Registered match for the Moore output; reconfiguration discards it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zq_reg <= 1'b0;
        end else if (bus.cfg_load) begin
            zq_reg <= 1'b0;
        end else begin
            zq_reg <= match;
        end
    end

    // Saturating match counter; a clear wins over a simultaneous match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (bus.cnt_clr) begin
            cnt_reg <= '0;
        end else if (match && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bus.z         = moore_reg ? zq_reg : match;
    assign bus.match_cnt = cnt_reg;
    assign bus.cfg_len   = len_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param. The stimulus process drives one
// cycle at a time and queues the hand-computed response for that cycle;
// an independent monitor samples the outputs mid-cycle and checks them.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        bit               cz;
        logic             ez;
        logic [CNT_W-1:0] ecnt;
        bit               cl;
        logic [LEN_W-1:0] elen;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Inputs change 1 time unit after the rising edge; expectation is queued.
    task automatic step(input logic s_en, input logic s_x, input logic s_cfg,
                        input logic s_clr, input logic s_rst,
                        input bit cz, input logic ez, input logic [CNT_W-1:0] ecnt,
                        input bit cl, input logic [LEN_W-1:0] elen, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = s_rst;
        bus.en       = s_en;
        bus.x        = s_x;
        bus.cfg_load = s_cfg;
        bus.cnt_clr  = s_clr;
        e.name = nm; e.cz = cz; e.ez = ez; e.ecnt = ecnt; e.cl = cl; e.elen = elen;
        sb_q.push_back(e);
    endtask

    task automatic bit_in(input logic x, input logic ez, input logic [CNT_W-1:0] ecnt,
                          input string nm);
        step(1'b1, x, 1'b0, 1'b0, 1'b0, 1'b1, ez, ecnt, 1'b0, '0, nm);
    endtask

    task automatic idle(input logic [CNT_W-1:0] ecnt, input logic [LEN_W-1:0] elen,
                        input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ecnt, 1'b1, elen, nm);
    endtask

    // Config cycle with en=1,x=1 present to show the bit is ignored.
    task automatic cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                       input logic ov, input logic mo, input logic clr,
                       input logic [CNT_W-1:0] ecnt, input string nm);
        bus.pattern    = pat;
        bus.pat_len    = len;
        bus.overlap_en = ov;
        bus.moore_mode = mo;
        step(1'b1, 1'b1, 1'b1, clr, 1'b0, 1'b1, 1'b0, ecnt, 1'b0, '0, nm);
    endtask

    // Monitor: compare the queued expectation against outputs at the falling edge.
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                tests++;
                bad = (e.cz && (bus.z !== e.ez)) || (bus.match_cnt !== e.ecnt) ||
                      (e.cl && (bus.cfg_len !== e.elen));
                if (bad) begin
                    fails++;
                    $display("FAIL %s: got z=%b cnt=%0d len=%0d, expected z=%b cnt=%0d len=%0d",
                             e.name, bus.z, bus.match_cnt, bus.cfg_len, e.ez, e.ecnt, e.elen);
                end else begin
                    $display("[TB] ok %s: z=%b cnt=%0d len=%0d",
                             e.name, bus.z, bus.match_cnt, bus.cfg_len);
                end
            end
        end
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b0; bus.x = 1'b0; bus.cfg_load = 1'b0; bus.cnt_clr = 1'b0;
        bus.pattern = '0; bus.pat_len = '0; bus.overlap_en = 1'b0; bus.moore_mode = 1'b0;

        // Reset state and disabled detection (cfg_len = 0)
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 4'd0, "reset");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 4'd0, "reset_en");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 4'd0, "disabled");

        // Overlapping Mealy 1010
        cfg(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b1, 2'd0, "ovl_cfg");
        bit_in(1, 0, 0, "ovl_b1"); bit_in(1, 0, 0, "ovl_b2");
        bit_in(0, 0, 0, "ovl_b3"); bit_in(1, 0, 0, "ovl_b4");
        bit_in(0, 1, 0, "ovl_b5"); bit_in(1, 0, 1, "ovl_b6");
        bit_in(0, 1, 1, "ovl_b7"); bit_in(0, 0, 2, "ovl_b8");
        idle(2'd2, 4'd4, "ovl_end");

        // Non-overlapping Mealy
        cfg(8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b1, 2'd2, "nov_cfg");
        bit_in(1, 0, 0, "nov_b1"); bit_in(1, 0, 0, "nov_b2");
        bit_in(0, 0, 0, "nov_b3"); bit_in(1, 0, 0, "nov_b4");
        bit_in(0, 1, 0, "nov_b5"); bit_in(1, 0, 1, "nov_b6");
        bit_in(0, 0, 1, "nov_b7"); bit_in(0, 0, 1, "nov_b8");
        idle(2'd1, 4'd4, "nov_end");

        // Overlapping Moore: z one cycle after the final bit
        cfg(8'b0000_1010, 4'd4, 1'b1, 1'b1, 1'b1, 2'd1, "moo_cfg");
        bit_in(1, 0, 0, "moo_b1"); bit_in(1, 0, 0, "moo_b2");
        bit_in(0, 0, 0, "moo_b3"); bit_in(1, 0, 0, "moo_b4");
        bit_in(0, 0, 0, "moo_b5"); bit_in(1, 1, 1, "moo_b6");
        bit_in(0, 0, 1, "moo_b7"); bit_in(0, 1, 2, "moo_b8");
        idle(2'd2, 4'd4, "moo_end");

        // Length 3, all ones, then counter saturation and clear-vs-match
        cfg(8'b0000_0111, 4'd3, 1'b1, 1'b0, 1'b1, 2'd2, "l3_cfg");
        bit_in(1, 0, 0, "l3_b1"); bit_in(1, 0, 0, "l3_b2");
        bit_in(1, 1, 0, "l3_b3"); bit_in(1, 1, 1, "l3_b4");
        bit_in(1, 1, 2, "l3_b5");
        idle(2'd3, 4'd3, "l3_end");
        bit_in(1, 1, 3, "sat_b6");
        idle(2'd3, 4'd3, "sat_hold");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, '0, "clr_with_match");
        idle(2'd0, 4'd3, "clr_result");
        bit_in(1, 1, 0, "post_clr_match");
        idle(2'd1, 4'd3, "post_clr_cnt");

        // Clamp: pat_len 15 becomes 8; cfg_load keeps the counter
        cfg(8'hA5, 4'd15, 1'b1, 1'b0, 1'b0, 2'd1, "clamp_cfg");
        idle(2'd1, 4'd8, "clamp_len");
        bit_in(1, 0, 1, "clamp_b1"); bit_in(0, 0, 1, "clamp_b2");
        bit_in(1, 0, 1, "clamp_b3"); bit_in(0, 0, 1, "clamp_b4");
        bit_in(0, 0, 1, "clamp_b5"); bit_in(1, 0, 1, "clamp_b6");
        bit_in(0, 0, 1, "clamp_b7"); bit_in(1, 1, 1, "clamp_b8");
        idle(2'd2, 4'd8, "clamp_end");

        // Zero length never matches, even with an all-zero pattern
        cfg(8'h00, 4'd0, 1'b1, 1'b0, 1'b1, 2'd2, "len0_cfg");
        bit_in(0, 0, 0, "len0_b1"); bit_in(0, 0, 0, "len0_b2");
        bit_in(0, 0, 0, "len0_b3"); bit_in(1, 0, 0, "len0_b4");
        idle(2'd0, 4'd0, "len0_end");

        // en gaps do not break a partial match
        cfg(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b1, 2'd0, "gap_cfg");
        bit_in(1, 0, 0, "gap_b1"); bit_in(0, 0, 0, "gap_b2");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, '0, "gap_off1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, '0, "gap_off2");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, '0, "gap_off3");
        bit_in(1, 0, 0, "gap_b3"); bit_in(0, 1, 0, "gap_b4");
        idle(2'd1, 4'd4, "gap_end");

        // Reset mid-stream clears everything immediately
        bit_in(1, 0, 1, "rst_b1"); bit_in(0, 1, 1, "rst_b2");
        bit_in(1, 0, 2, "rst_b3");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 4'd0, "rst_mid");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 4'd0, "rst_after");
        idle(2'd0, 4'd0, "rst_end");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; next generation of the fixed 4-bit "1010" Mealy detector.
- Pattern and length are runtime-programmable up to MAX_LEN bits. Overlapping or non-overlapping detection is selectable.
- Output style is selectable: Mealy (same-cycle) or Moore (registered, one cycle later).
- Provides a saturating match counter. Sits on a serial input line in the datapath, feeding status/interrupt logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of pat_len. Must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 8, width of match counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  x is sampled and processed only when en=1.
- x  input  1  serial data bit.
- cfg_load  input  1  one-cycle pulse; latches pattern, pat_len, overlap_en, moore_mode.
- pattern  input  MAX_LEN  pattern bits. pattern[pat_len-1] is the first bit received; pattern[0] is the last.
- pat_len  input  LEN_W  pattern length.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- moore_mode  input  1  1 = registered output, 0 = combinational Mealy output.
- cnt_clr  input  1  synchronous clear of match_cnt.
- z  output  1  match indication.
- match_cnt  output  CNT_W  number of matches, saturating.
- cfg_len  output  LEN_W  effective (clamped) length currently active.

Behaviour:
- Reset state:
  - pattern register = 0, cfg_len = 0 (detection disabled).
  - overlap = 1, moore = 0.
  - History register and its valid count cleared.
  - z = 0, match_cnt = 0.
- Config (cfg_load=1):
  - On that clock edge, latch pattern, overlap_en and moore_mode.
  - cfg_len = pat_len, clamped to MAX_LEN if pat_len > MAX_LEN.
  - Clear history, valid count and the Moore output register.
  - x is ignored in the cfg_load cycle. cfg_load has priority over en.
  - Mealy z is forced to 0 during the cfg_load cycle.
- History:
  - hist is a MAX_LEN-bit shift register; the newest bit is at bit 0.
  - vcnt counts valid bits and saturates at MAX_LEN.
  - Each clock with en=1 and no cfg_load: hist <= {hist[MAX_LEN-2:0], x}, vcnt increments.
  - With en=0, hist and vcnt hold.
- Match event, evaluated combinationally:
  - match = en & ~cfg_load & (cfg_len != 0) & (vcnt >= cfg_len-1) & ({hist,x} low cfg_len bits == pattern low cfg_len bits).
  - cfg_len = 0 means match is never asserted.
  - cfg_len = 1 matches on every x equal to pattern[0].
- Overlap handling:
  - overlap=1: history continues to shift normally after a match.
  - overlap=0: on a match edge, vcnt <= 0 and hist <= 0. The matching bit is consumed and not reused.
- Output:
  - moore=0: z = match, same cycle as the final pattern bit.
  - moore=1: z_q <= match on each edge and z = z_q, i.e. high for exactly one cycle, one cycle after the final bit.
  - A mode change takes effect only through cfg_load.
- Counter:
  - match_cnt increments on each clock edge where match=1, in both modes.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment. cnt_clr with match in the same cycle gives 0.
  - cfg_load does not clear match_cnt.
- rst asserted mid-stream: all state clears immediately and z drops to 0 asynchronously. The first valid bit after release starts a fresh history.
- en=0 mid-pattern: a gap does not break a partial match; bits are matched by en-qualified sequence, not by time.

Test Plan:
- Overlap Mealy: cfg pattern=8'b00001010, len=4, overlap=1, moore=0; x=1,1,0,1,0,1,0,0 with en=1 -> z high on the 5th and 7th bits (same cycle); match_cnt=2.
- Non-overlap: same stream with overlap=0 -> z high on the 5th bit only; match_cnt=1.
- Moore timing: overlap=1, moore=1, same stream -> z high for one cycle on the cycle after the 5th bit and on the cycle after the 7th bit; never high in the cycle of the final bit.
- Length and clamp:
  - len=3 pattern=3'b111, x=1,1,1,1,1, overlap=1 -> matches on bits 3,4,5.
  - pat_len=15 -> cfg_len reads 8.
  - pat_len=0 -> no match for any stream.
- Gaps and reset:
  - Stream 1,0,[en=0 for 3 cycles],1,0 -> match on the final 0.
  - rst pulse after 1,0,1 then x=0 -> no match; z=0 and match_cnt=0 right after rst.
- Counter: CNT_W=2, len=1 pattern=1, x=1 for 5 cycles -> match_cnt saturates at 3. cnt_clr with a simultaneous match -> match_cnt=0.
